// File: rtl/input_buffer_pingpong_if.sv
// rtl/input_buffer_pingpong_if.sv - input/output stream handshake bundle for the ping-pong A-operand buffer
interface input_buffer_pingpong_if #(
    parameter int ROWS       = 4,
    parameter int DATA_WIDTH = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [ROWS*DATA_WIDTH-1:0] in_data;
    logic [7:0]                 stream_reps;
    logic                       out_valid;
    logic                       out_ready;
    logic [ROWS*DATA_WIDTH-1:0] out_data;
    logic                       out_last;
    logic                       busy;

    modport master (
        output in_valid, in_data, stream_reps, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, stream_reps, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/input_buffer_pingpong.sv
// rtl/input_buffer_pingpong.sv - double-buffered tile store streaming skewed columns into the systolic array
module input_buffer_pingpong #(
    parameter int ROWS       = 4,
    parameter int COLS       = 64,
    parameter int DATA_WIDTH = 16,
    parameter int SKEW_EN    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input_buffer_pingpong_if.slave   bus
);
    localparam int NB = (SKEW_EN != 0) ? COLS + ROWS - 1 : COLS;
    localparam int CW = $clog2(COLS);
    localparam int KW = $clog2(NB);
    localparam int W  = ROWS * DATA_WIDTH;

    typedef enum logic {IDLE, STREAM} state_t;

    logic [DATA_WIDTH-1:0] mem [2][ROWS][COLS];
    logic [1:0]            full;
    logic [7:0]            reps_q [2];
    logic                  wr_bank;
    logic [CW-1:0]         wr_col;
    logic                  rd_bank;
    state_t                state;
    logic [KW-1:0]         k;
    logic [7:0]            rep;
    logic [W-1:0]          out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;

    logic                  wr_fire;
    logic                  pend;
    logic                  load;
    logic                  pass_end;
    logic                  rep_end;
    logic [KW-1:0]         cur_k;
    logic [7:0]            cur_rep;
    logic [W-1:0]          beat;
    int                    idx;

    assign wr_fire  = bus.in_valid && !full[wr_bank];
    // IDLE with a full bank presents beat 0 directly so the first beat appears two cycles after the last write
    assign pend     = (state == STREAM) || full[rd_bank];
    assign cur_k    = (state == STREAM) ? k : '0;
    assign cur_rep  = (state == STREAM) ? rep : '0;
    assign load     = pend && (!out_valid_q || bus.out_ready);
    assign pass_end = (cur_k == KW'(NB - 1));
    assign rep_end  = (cur_rep == reps_q[rd_bank] - 8'd1);

    always_comb begin
        beat = '0;
        idx  = 0;
        for (int r = 0; r < ROWS; r++) begin
            idx = (SKEW_EN != 0) ? int'(cur_k) - r : int'(cur_k);
            if (idx >= 0 && idx < COLS)
                beat[r*DATA_WIDTH +: DATA_WIDTH] = mem[rd_bank][r][idx[CW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int r = 0; r < ROWS; r++)
                mem[wr_bank][r][wr_col] <= bus.in_data[r*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full        <= '0;
            reps_q[0]   <= 8'd1;
            reps_q[1]   <= 8'd1;
            wr_bank     <= 1'b0;
            wr_col      <= '0;
            rd_bank     <= 1'b0;
            state       <= IDLE;
            k           <= '0;
            rep         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_col == CW'(COLS - 1)) begin
                    full[wr_bank]   <= 1'b1;
                    reps_q[wr_bank] <= (bus.stream_reps == 8'd0) ? 8'd1 : bus.stream_reps;
                    wr_col          <= '0;
                    wr_bank         <= ~wr_bank;
                end else begin
                    wr_col <= wr_col + CW'(1);
                end
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= beat;
                out_last_q  <= pass_end && rep_end;
                if (!pass_end) begin
                    k     <= cur_k + KW'(1);
                    rep   <= cur_rep;
                    state <= STREAM;
                end else if (!rep_end) begin
                    k     <= '0;
                    rep   <= cur_rep + 8'd1;
                    state <= STREAM;
                end else begin
                    // the writer can only complete the other bank here, so both full[] updates never collide
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    k             <= '0;
                    rep           <= '0;
                    state         <= full[~rd_bank] ? STREAM : IDLE;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = !full[wr_bank];
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (|full) || out_valid_q;
endmodule

// File: tb/tb_input_buffer_pingpong.sv
// tb/tb_input_buffer_pingpong.sv - directed self-checking bench for input_buffer_pingpong
`timescale 1ns/1ps
module tb_input_buffer_pingpong;
    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int DW   = 16;
    localparam int W    = ROWS * DW;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         which;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic [7:0]   stream_reps;
    logic         out_ready;
    logic         in_ready, out_valid, out_last, busy;
    logic [W-1:0] out_data;

    int    ntests = 0;
    int    nfail  = 0;
    beat_t expq[$];
    int    nbeats, nlast, ngaps, nstall;

    always #5 clk = ~clk;

    input_buffer_pingpong_if #(.ROWS(ROWS), .DATA_WIDTH(DW)) bus0 ();
    input_buffer_pingpong_if #(.ROWS(ROWS), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.in_valid    = in_valid && !which;
    assign bus1.in_valid    = in_valid && which;
    assign bus0.in_data     = in_data;
    assign bus1.in_data     = in_data;
    assign bus0.stream_reps = stream_reps;
    assign bus1.stream_reps = stream_reps;
    assign bus0.out_ready   = out_ready;
    assign bus1.out_ready   = out_ready;

    assign in_ready  = which ? bus1.in_ready  : bus0.in_ready;
    assign out_valid = which ? bus1.out_valid : bus0.out_valid;
    assign out_data  = which ? bus1.out_data  : bus0.out_data;
    assign out_last  = which ? bus1.out_last  : bus0.out_last;
    assign busy      = which ? bus1.busy      : bus0.busy;

    input_buffer_pingpong #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .SKEW_EN(1)) u_skew (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    input_buffer_pingpong #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .SKEW_EN(0)) u_flat (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    function automatic logic [DW-1:0] word(input int t, input int r, input int c);
        return DW'(t * 256 + r * 16 + c);
    endfunction

    function automatic logic [W-1:0] col_data(input int t, input int c);
        logic [W-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = word(t, r, c);
        return v;
    endfunction

    function automatic logic [W-1:0] exp_beat(input int t, input int kk, input bit skew);
        logic [W-1:0] v;
        int           c;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            c = skew ? kk - r : kk;
            if (c >= 0 && c < COLS) v[r*DW +: DW] = word(t, r, c);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
        ntests++;
        assert (obs === want) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int ntiles, input int base, input int r0, input int r1, input int r2,
                       input bit rnd);
        int  reps_a[3];
        int  nb, total, t, col, cyc, er;
        bit  started;
        beat_t b;
        reps_a  = '{r0, r1, r2};
        nb      = which ? COLS : COLS + ROWS - 1;
        total   = 0;
        for (int i = 0; i < ntiles; i++) total += ((reps_a[i] == 0) ? 1 : reps_a[i]) * nb;
        expq.delete();
        nbeats = 0; nlast = 0; ngaps = 0; nstall = 0;
        t = 0; col = 0; cyc = 0; started = 0;
        while (nbeats < total && cyc < 1000) begin
            if (t < ntiles) begin
                in_valid    = 1'b1;
                in_data     = col_data(base + t, col);
                stream_reps = (col == COLS - 1) ? 8'(reps_a[t]) : 8'd5;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_valid && !in_ready) nstall++;
            if (out_valid) begin
                started = 1;
                if (expq.size() == 0) begin
                    chk("unexpected_beat", W'(out_valid), '0);
                end else begin
                    chk("beat_data", out_data, expq[0].d);
                    chk("beat_last", W'(out_last), W'(expq[0].l));
                    if (out_ready) begin
                        if (out_last) nlast++;
                        void'(expq.pop_front());
                        nbeats++;
                    end
                end
            end else if (started) begin
                ngaps++;
            end
            if (in_valid && in_ready) begin
                if (col == COLS - 1) begin
                    er = (reps_a[t] == 0) ? 1 : reps_a[t];
                    for (int rp = 0; rp < er; rp++)
                        for (int kk = 0; kk < nb; kk++) begin
                            b.d = exp_beat(base + t, kk, !which);
                            b.l = (kk == nb - 1) && (rp == er - 1);
                            expq.push_back(b);
                        end
                    col = 0;
                    t++;
                end else begin
                    col++;
                end
            end
            step();
            cyc++;
        end
        chk("run_timeout", W'(cyc < 1000), W'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("drain_valid", W'(out_valid), '0);
    endtask

    initial begin
        which       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        stream_reps = 8'd1;
        out_ready   = 1'b1;
        rst         = 1'b1;
        step();
        step();
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", W'(out_last), '0);
        chk("rst_busy", W'(busy), '0);
        rst = 1'b0;
        step();

        // single skewed tile, reps=1, latency and hand-computed beats
        for (int c = 0; c < COLS; c++) begin
            in_valid    = 1'b1;
            in_data     = col_data(0, c);
            stream_reps = 8'd1;
            if (c == 0) chk("t1_in_ready", W'(in_ready), W'(1));
            step();
        end
        in_valid = 1'b0;
        chk("t1_lat_n1_valid", W'(out_valid), '0);
        chk("t1_lat_n1_busy", W'(busy), W'(1));
        step();
        chk("t1_lat_n2_valid", W'(out_valid), W'(1));
        for (int b = 0; b < 11; b++) begin
            chk("t1_valid", W'(out_valid), W'(1));
            chk("t1_last", W'(out_last), W'(b == 10));
            if (b == 0)  chk("t1_beat0", out_data, 64'h0000_0000_0000_0000);
            if (b == 3)  chk("t1_beat3", out_data, 64'h0030_0021_0012_0003);
            if (b == 10) chk("t1_beat10", out_data, 64'h0037_0000_0000_0000);
            step();
        end
        chk("t1_end_valid", W'(out_valid), '0);
        chk("t1_end_busy", W'(busy), '0);
        chk("t1_end_in_ready", W'(in_ready), W'(1));

        // aligned rows, three repeats
        which = 1'b1;
        run(1, 1, 3, 0, 0, 1'b0);
        chk("t2_beats", W'(nbeats), W'(24));
        chk("t2_lasts", W'(nlast), W'(1));

        // three back-to-back tiles with continuous input
        which = 1'b0;
        run(3, 2, 1, 1, 1, 1'b0);
        chk("t3_beats", W'(nbeats), W'(33));
        chk("t3_gaps", W'(ngaps), '0);
        chk("t3_in_stalls", W'(nstall), W'(3));

        // random output backpressure with mixed repeat counts
        run(3, 5, 2, 1, 3, 1'b1);
        chk("t4_beats", W'(nbeats), W'(66));
        chk("t4_lasts", W'(nlast), W'(3));

        // stream_reps=0 behaves as one pass
        run(1, 8, 0, 0, 0, 1'b0);
        chk("t5_beats_skew", W'(nbeats), W'(11));
        which = 1'b1;
        run(1, 9, 0, 0, 0, 1'b0);
        chk("t5_beats_flat", W'(nbeats), W'(8));

        // reset while streaming with the other bank half loaded
        which     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            in_valid    = 1'b1;
            in_data     = col_data(10, c);
            stream_reps = 8'd1;
            step();
        end
        for (int c = 0; c < 4; c++) begin
            in_data = col_data(11, c);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("t6_beat5_valid", W'(out_valid), W'(1));
        chk("t6_beat5_data", out_data, exp_beat(10, 5, 1'b1));
        rst = 1'b1;
        step();
        chk("t6_rst_valid", W'(out_valid), '0);
        chk("t6_rst_in_ready", W'(in_ready), W'(1));
        chk("t6_rst_busy", W'(busy), '0);
        chk("t6_rst_last", W'(out_last), '0);
        rst = 1'b0;
        step();
        run(1, 12, 1, 0, 0, 1'b0);
        chk("t6_fresh_beats", W'(nbeats), W'(11));
        chk("t6_fresh_lasts", W'(nlast), W'(1));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
